// File: rtl/offset_cal_ctrl.sv
//============================================================================
// Module      : offset_cal_ctrl
// Description : Closed-loop offset calibration sequencer for the two-channel
//               gain_control stage. Drives both offset controls, measures the
//               mean of each channel over a fixed window and corrects each
//               offset until both means sit within tolerance of a target code.
// Revision    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module offset_cal_ctrl #(
    parameter int                 LOG2_NSAMP    = 10,
    parameter int                 SETTLE_CYCLES = 16,
    parameter int                 MAX_ITER      = 8,
    parameter logic signed [15:0] TARGET        = 16'sd0,
    parameter int                 TOL           = 2
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic signed [15:0] host_offset_1_i,
    input  logic signed [15:0] host_offset_2_i,
    input  logic signed [15:0] y0_i,
    input  logic signed [15:0] y0z_i,
    input  logic signed [15:0] y1_i,
    input  logic signed [15:0] y1z_i,
    output logic signed [15:0] offset_control_1_o,
    output logic signed [15:0] offset_control_2_o,
    output logic signed [15:0] mean_1_o,
    output logic signed [15:0] mean_2_o,
    output logic [3:0]         iter_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o
);

    // Two 16-bit samples per cycle over 2^LOG2_NSAMP cycles: 17+LOG2_NSAMP
    // bits hold the worst-case sum without overflow.
    localparam int                    ACC_W      = 17 + LOG2_NSAMP;
    localparam logic [7:0]            C_SETTLE   = 8'(SETTLE_CYCLES);
    localparam logic [3:0]            C_MAX_ITER = 4'(MAX_ITER);
    localparam logic [16:0]           C_TOL      = 17'(TOL);
    localparam logic [LOG2_NSAMP-1:0] C_ACC_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_EVAL   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_settle_cnt;
    logic [LOG2_NSAMP-1:0]   r_acc_cnt;
    logic signed [ACC_W-1:0] r_acc_1;
    logic signed [ACC_W-1:0] r_acc_2;

    logic signed [ACC_W-1:0] w_samp_1;
    logic signed [ACC_W-1:0] w_samp_2;
    logic signed [15:0]      w_mean_1;
    logic signed [15:0]      w_mean_2;
    logic signed [16:0]      w_err_1;
    logic signed [16:0]      w_err_2;
    logic                    w_conv_1;
    logic                    w_conv_2;
    logic signed [15:0]      w_next_off_1;
    logic signed [15:0]      w_next_off_2;
    logic [3:0]              w_iter_next;

    // err = TARGET - mean, widened to 17 bits so it can never wrap
    function automatic logic signed [16:0] f_err(input logic signed [15:0] mean);
        logic [16:0] diff;
        diff = {TARGET[15], TARGET} - {mean[15], mean};
        return diff;
    endfunction

    // A channel is converged when |err| does not exceed the tolerance
    function automatic logic f_conv(input logic signed [16:0] err);
        logic [16:0] mag;
        mag = err[16] ? (17'd0 - err) : err;
        return (mag <= C_TOL);
    endfunction

    // offset + err, clamped to the signed 16-bit range instead of wrapping
    function automatic logic signed [15:0] f_sat_add(input logic signed [15:0] off,
                                                     input logic signed [16:0] err);
        logic [17:0] sum;
        sum = {{2{off[15]}}, off} + {err[16], err};
        if ((sum[17:15] == 3'b000) || (sum[17:15] == 3'b111)) begin
            return sum[15:0];
        end else if (sum[17]) begin
            return 16'h8000;
        end else begin
            return 16'h7FFF;
        end
    endfunction

    // Per-cycle sample pair sums and end-of-window evaluation terms
    always_comb begin
        w_samp_1 = {{(ACC_W-16){y0_i[15]}}, y0_i} + {{(ACC_W-16){y0z_i[15]}}, y0z_i};
        w_samp_2 = {{(ACC_W-16){y1_i[15]}}, y1_i} + {{(ACC_W-16){y1z_i[15]}}, y1z_i};
        // Arithmetic shift by LOG2_NSAMP+1 keeping the low 16 bits is just
        // this slice of the accumulator.
        w_mean_1 = r_acc_1[LOG2_NSAMP+16:LOG2_NSAMP+1];
        w_mean_2 = r_acc_2[LOG2_NSAMP+16:LOG2_NSAMP+1];
        w_err_1  = f_err(w_mean_1);
        w_err_2  = f_err(w_mean_2);
        w_conv_1 = f_conv(w_err_1);
        w_conv_2 = f_conv(w_err_2);
        w_next_off_1 = w_conv_1 ? offset_control_1_o : f_sat_add(offset_control_1_o, w_err_1);
        w_next_off_2 = w_conv_2 ? offset_control_2_o : f_sat_add(offset_control_2_o, w_err_2);
        w_iter_next  = iter_o + 4'd1;
    end

    // Calibration sequencer: state, counters, accumulators and all outputs
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state            <= S_IDLE;
            r_settle_cnt       <= 8'd0;
            r_acc_cnt          <= '0;
            r_acc_1            <= '0;
            r_acc_2            <= '0;
            offset_control_1_o <= 16'sd0;
            offset_control_2_o <= 16'sd0;
            mean_1_o           <= 16'sd0;
            mean_2_o           <= 16'sd0;
            iter_o             <= 4'd0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            fail_o             <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if ((r_state != S_IDLE) && abort_i) begin
                // Abort freezes offsets, means, iteration count and fail flag
                r_state <= S_IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            offset_control_1_o <= host_offset_1_i;
                            offset_control_2_o <= host_offset_2_i;
                            iter_o             <= 4'd0;
                            fail_o             <= 1'b0;
                            r_acc_1            <= '0;
                            r_acc_2            <= '0;
                            r_settle_cnt       <= C_SETTLE;
                            busy_o             <= 1'b1;
                            r_state            <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        // Samples seen here reflect the old offset and are dropped
                        if (r_settle_cnt == 8'd1) begin
                            r_acc_1   <= '0;
                            r_acc_2   <= '0;
                            r_acc_cnt <= '0;
                            r_state   <= S_ACCUM;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 8'd1;
                        end
                    end
                    S_ACCUM: begin
                        r_acc_1   <= r_acc_1 + w_samp_1;
                        r_acc_2   <= r_acc_2 + w_samp_2;
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (r_acc_cnt == C_ACC_LAST) begin
                            r_state <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        mean_1_o           <= w_mean_1;
                        mean_2_o           <= w_mean_2;
                        offset_control_1_o <= w_next_off_1;
                        offset_control_2_o <= w_next_off_2;
                        iter_o             <= w_iter_next;
                        if (w_conv_1 && w_conv_2) begin
                            r_state <= S_IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else if (w_iter_next == C_MAX_ITER) begin
                            r_state <= S_IDLE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            fail_o  <= 1'b1;
                        end else begin
                            r_settle_cnt <= C_SETTLE;
                            r_state      <= S_SETTLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_offset_cal_ctrl.sv
//============================================================================
// Module      : tb_offset_cal_ctrl
// Description : Self-checking bench for offset_cal_ctrl. A behavioural plant
//               closes the loop around the DUT; a reference model predicts
//               each run's outcome into a scoreboard popped on done_o.
// Revision    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_offset_cal_ctrl;

    localparam int S    = 16;
    localparam int L    = 10;
    localparam int MAXI = 8;
    localparam int TGT  = 0;
    localparam int TOLV = 2;
    localparam int T    = S + (1 << L) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i   = 1'b1;
    logic               start_i = 1'b0;
    logic               abort_i = 1'b0;
    logic signed [15:0] host_offset_1_i = 16'sd0;
    logic signed [15:0] host_offset_2_i = 16'sd0;
    logic signed [15:0] y0_i, y0z_i, y1_i, y1z_i;
    logic signed [15:0] offset_control_1_o, offset_control_2_o;
    logic signed [15:0] mean_1_o, mean_2_o;
    logic [3:0]         iter_o;
    logic               busy_o, done_o, fail_o;

    // Plant parameters per channel: input level, offset gain mode, z-sample skew
    int xv[2]  = '{0, 0};
    int mv[2]  = '{1, 1};
    int dzv[2] = '{0, 0};

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int iter; int fail; int off1; int off2; int mean1; int mean2; int cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    offset_cal_ctrl #(
        .LOG2_NSAMP(L), .SETTLE_CYCLES(S), .MAX_ITER(MAXI),
        .TARGET(16'sd0), .TOL(TOLV)
    ) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .host_offset_1_i(host_offset_1_i), .host_offset_2_i(host_offset_2_i),
        .y0_i(y0_i), .y0z_i(y0z_i), .y1_i(y1_i), .y1z_i(y1z_i),
        .offset_control_1_o(offset_control_1_o), .offset_control_2_o(offset_control_2_o),
        .mean_1_o(mean_1_o), .mean_2_o(mean_2_o), .iter_o(iter_o),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o)
    );

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((d - 1 - a) / d);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // mode 0: offset ignored, 1: y = x + off, 2: x + off/2, 3: x + off/4
    function automatic int plant(input int x, input int off, input int mode);
        int eff;
        eff = (mode == 0) ? 0 : fdiv(off, 1 << (mode - 1));
        return sat16(x + eff);
    endfunction

    // Plant feeding the DUT from its own offset outputs
    always_comb begin
        int t0, t1;
        t0    = plant(xv[0], int'(offset_control_1_o), mv[0]);
        t1    = plant(xv[1], int'(offset_control_2_o), mv[1]);
        y0_i  = 16'(t0);
        y0z_i = 16'(sat16(t0 + dzv[0]));
        y1_i  = 16'(t1);
        y1z_i = 16'(sat16(t1 + dzv[1]));
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Predicts a whole calibration run from the loop rules
    function automatic exp_t ref_model(input int h1, input int h2, input int k);
        exp_t e;
        int off[2], mean[2], err, y, yz, it;
        bit conv[2];
        off[0] = h1; off[1] = h2; it = 0; e.fail = 0;
        mean[0] = 0; mean[1] = 0;
        for (int i = 0; i < MAXI; i++) begin
            for (int c = 0; c < 2; c++) begin
                y       = plant(xv[c], off[c], mv[c]);
                yz      = sat16(y + dzv[c]);
                mean[c] = fdiv(y + yz, 2);
                err     = TGT - mean[c];
                conv[c] = (err <= TOLV) && (err >= -TOLV);
                if (!conv[c]) off[c] = sat16(off[c] + err);
            end
            it++;
            if (conv[0] && conv[1]) break;
            if (it == MAXI) e.fail = 1;
        end
        e.iter = it; e.off1 = off[0]; e.off2 = off[1];
        e.mean1 = mean[0]; e.mean2 = mean[1];
        e.cyc = k + it * T;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every done_o pulse must match the oldest predicted run
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done_o, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("iter", iter_o, mon_e.iter);
                chk("fail", fail_o, mon_e.fail);
                chk("offset_1", offset_control_1_o, mon_e.off1);
                chk("offset_2", offset_control_2_o, mon_e.off2);
                chk("mean_1", mean_1_o, mon_e.mean1);
                chk("mean_2", mean_2_o, mon_e.mean2);
                chk("busy_at_done", busy_o, 0);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_run(input int h1, input int h2, input bit push, output int k);
        @(negedge clk);
        host_offset_1_i = 16'(h1);
        host_offset_2_i = 16'(h2);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k = cyc;
        chk("busy_after_start", busy_o, 1);
        chk("fail_cleared_at_start", fail_o, 0);
        chk("offset_1_loaded", offset_control_1_o, h1);
        chk("offset_2_loaded", offset_control_2_o, h2);
        if (push) sb.push_back(ref_model(h1, h2, k));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < (MAXI + 1) * T) begin
            @(negedge clk);
            n++;
        end
        chk("run_completed", sb.size(), 0);
        chk("idle_after_run", busy_o, 0);
    endtask

    task automatic pulse_start_busy();
        host_offset_1_i = 16'sd1234;
        host_offset_2_i = 16'sd1234;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        host_offset_1_i = 16'sd0;
        host_offset_2_i = 16'sd0;
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_offset_1", offset_control_1_o, 0);
        chk("rst_offset_2", offset_control_2_o, 0);
        chk("rst_mean_1", mean_1_o, 0);
        chk("rst_mean_2", mean_2_o, 0);
        chk("rst_iter", iter_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_fail", fail_o, 0);
        rst_i = 1'b0;

        // Unity loop gain, plus start pulses while busy that must be ignored
        xv = '{100, 100}; mv = '{1, 1}; dzv = '{0, 0};
        start_run(0, 0, 1'b1, k);
        wait_cyc(k + 5);
        pulse_start_busy();
        wait_cyc(k + S + 10);
        pulse_start_busy();
        wait_cyc(k + T);
        chk("A_offset_1_it1", offset_control_1_o, -100);
        chk("A_iter_it1", iter_o, 1);
        chk("A_mean_1_it1", mean_1_o, 100);
        wait_done();

        // Channel 1 already inside tolerance, channel 2 off by -50
        xv = '{1, -50};
        start_run(0, 0, 1'b1, k);
        wait_cyc(k + T);
        chk("B_offset_1_it1", offset_control_1_o, 0);
        chk("B_offset_2_it1", offset_control_2_o, 50);
        wait_done();

        // Loop gain 0.25 cannot converge in MAX_ITER iterations
        xv = '{400, 400}; mv = '{3, 3};
        start_run(0, 0, 1'b1, k);
        wait_done();
        chk("C_fail_sticky", fail_o, 1);

        // Next start clears fail_o (checked inside start_run)
        xv = '{100, -100}; mv = '{1, 1};
        start_run(0, 0, 1'b1, k);
        wait_done();

        // Offsets that cannot influence the output drive into saturation
        xv = '{-20000, 20000}; mv = '{0, 0};
        start_run(30000, -30000, 1'b1, k);
        wait_cyc(k + T);
        chk("sat_offset_1_it1", offset_control_1_o, 32767);
        chk("sat_offset_2_it1", offset_control_2_o, -32768);
        wait_cyc(k + 2 * T);
        chk("sat_offset_1_it2", offset_control_1_o, 32767);
        wait_done();

        // Abort in ACCUM of iteration 2, with a simultaneous start
        xv = '{100, 100}; mv = '{1, 1};
        start_run(0, 0, 1'b0, k);
        wait_cyc(k + T + S + 100);
        abort_i = 1'b1; start_i = 1'b1;
        host_offset_1_i = 16'sd777; host_offset_2_i = 16'sd777;
        @(posedge clk);
        #1;
        abort_i = 1'b0; start_i = 1'b0;
        host_offset_1_i = 16'sd0; host_offset_2_i = 16'sd0;
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_iter", iter_o, 1);
        chk("abort_offset_1", offset_control_1_o, -100);
        chk("abort_offset_2", offset_control_2_o, -100);
        chk("abort_mean_1", mean_1_o, 100);
        repeat (20) @(negedge clk);
        chk("abort_no_restart", busy_o, 0);

        // Synchronous reset while settling
        start_run(500, -500, 1'b0, k);
        wait_cyc(k + 5);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_offset_1", offset_control_1_o, 0);
        chk("mid_rst_offset_2", offset_control_2_o, 0);
        chk("mid_rst_mean_1", mean_1_o, 0);
        chk("mid_rst_mean_2", mean_2_o, 0);
        chk("mid_rst_iter", iter_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy_o, 0);

        // Randomised plants
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                xv[c]  = int'($urandom_range(6000, 0)) - 3000;
                mv[c]  = int'($urandom_range(3, 1));
                dzv[c] = int'($urandom_range(6, 0)) - 3;
            end
            start_run(int'($urandom_range(1000, 0)) - 500,
                      int'($urandom_range(1000, 0)) - 500, 1'b1, k);
            wait_done();
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
